// File: rtl/stage_accum.sv
// stage_accum: sums signed leaf values per cascade stage, checks each stage sum
// against its threshold and emits one pass/reject verdict per detection window.
module stage_accum #(
    parameter int W_LEAF            = 14,
    parameter int W_ACC             = 20,
    parameter int W_STAGE_THRESHOLD = 12,
    parameter int STAGE_NUM         = 25,
    localparam int W_STAGE          = $clog2(STAGE_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [W_LEAF-1:0]            din_data,
    input  logic                         din_eot,
    output logic [W_STAGE-1:0]           stage_addr,
    input  logic [W_STAGE_THRESHOLD-1:0] stage_threshold,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic                         result_pass,
    output logic [W_STAGE-1:0]           result_stage
);
    localparam logic [W_STAGE-1:0] LAST = W_STAGE'(STAGE_NUM - 1);
    typedef enum logic [1:0] {ACCUM, DISCARD, RESULT} state_t;
    state_t state;
    logic signed [W_ACC-1:0] acc, sum, thr;
    logic signed [W_ACC:0] sum_w;
    logic [W_STAGE-1:0] stage_cnt;
    logic beat, last, pass_stage;
    // one guard bit detects overflow; clamp toward the sign of the true result
    assign sum_w = (W_ACC+1)'(acc) + (W_ACC+1)'($signed(din_data));
    assign sum = (sum_w[W_ACC] != sum_w[W_ACC-1]) ?
                 {sum_w[W_ACC], {(W_ACC-1){~sum_w[W_ACC]}}} : sum_w[W_ACC-1:0];
    assign thr = W_ACC'($signed(stage_threshold));
    assign pass_stage = sum >= thr;
    assign last = stage_cnt == LAST;
    assign din_ready = rst & (state != RESULT);
    assign beat = din_valid & din_ready;
    assign stage_addr = stage_cnt;
    assign result_valid = state == RESULT;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ACCUM;
            acc          <= '0;
            stage_cnt    <= '0;
            result_pass  <= 1'b0;
            result_stage <= '0;
        end else begin
            case (state)
                ACCUM: if (beat) begin
                    if (!din_eot) acc <= sum;
                    else if (pass_stage) begin
                        if (last) begin
                            result_pass  <= 1'b1;
                            result_stage <= LAST;
                            state        <= RESULT;
                        end else begin
                            acc       <= '0;
                            stage_cnt <= stage_cnt + 1'b1;
                        end
                    end else begin
                        result_pass  <= 1'b0;
                        result_stage <= stage_cnt;
                        acc          <= '0;
                        if (last) state <= RESULT;
                        else begin
                            stage_cnt <= stage_cnt + 1'b1;
                            state     <= DISCARD;
                        end
                    end
                end
                DISCARD: if (beat && din_eot) begin
                    if (last) state <= RESULT;
                    else stage_cnt <= stage_cnt + 1'b1;
                end
                RESULT: if (result_ready) begin
                    acc       <= '0;
                    stage_cnt <= '0;
                    state     <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_accum.sv
// tb_stage_accum: directed checks of stage_accum with STAGE_NUM=3, W_ACC=16.
module tb_stage_accum;
    logic clk = 1'b0, rst = 1'b0;
    logic din_valid = 1'b0, din_eot = 1'b0, result_ready = 1'b0;
    logic [13:0] din_data = '0;
    logic [15:0] stage_threshold;
    logic [1:0] stage_addr, result_stage;
    logic din_ready, result_valid, result_pass;
    logic signed [15:0] thr [3];
    int n_cmp = 0, n_bad = 0;

    stage_accum #(.W_LEAF(14), .W_ACC(16), .W_STAGE_THRESHOLD(16), .STAGE_NUM(3)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_eot(din_eot), .stage_addr(stage_addr),
        .stage_threshold(stage_threshold), .result_valid(result_valid),
        .result_ready(result_ready), .result_pass(result_pass), .result_stage(result_stage)
    );

    always #5 clk = ~clk;
    assign stage_threshold = (stage_addr < 2'd3) ? thr[stage_addr] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int data, input logic eot);
        din_valid = 1'b1;
        din_data  = 14'(data);
        din_eot   = eot;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_eot   = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic pass, input logic [1:0] stg);
        check({tag, "_valid"}, 32'(result_valid), 1);
        check({tag, "_pass"}, 32'(result_pass), 32'(pass));
        check({tag, "_stage"}, 32'(result_stage), 32'(stg));
        check({tag, "_ready_low"}, 32'(din_ready), 0);
    endtask

    task automatic consume(input string tag);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({tag, "_drop"}, 32'(result_valid), 0);
        check({tag, "_rdy"}, 32'(din_ready), 1);
        check({tag, "_addr0"}, 32'(stage_addr), 0);
    endtask

    task automatic set_thr(input int a, input int b, input int c);
        thr[0] = 16'(a);
        thr[1] = 16'(b);
        thr[2] = 16'(c);
    endtask

    initial begin
        set_thr(10, -5, 20);
        #1;
        check("rst_valid", 32'(result_valid), 0);
        check("rst_ready", 32'(din_ready), 0);
        check("rst_pass", 32'(result_pass), 0);
        check("rst_stage", 32'(result_stage), 0);
        check("rst_addr", 32'(stage_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ready", 32'(din_ready), 1);
        @(posedge clk);
        #1;

        // all stages pass: sums 11, -3, 20
        send(4, 0); send(7, 1);
        check("t1_addr1", 32'(stage_addr), 1);
        send(-3, 1); send(15, 0);
        check("t1_addr2", 32'(stage_addr), 2);
        check("t1_early", 32'(result_valid), 0);
        send(5, 1);
        verdict("t1", 1'b1, 2'd2);
        consume("t1");

        // stage 0 fails (9 < 10); remaining beats are discarded
        send(4, 0); send(5, 1);
        check("t2_disc_rdy", 32'(din_ready), 1);
        check("t2_disc_addr", 32'(stage_addr), 1);
        send(1, 0); send(1, 1);
        check("t2_disc_addr2", 32'(stage_addr), 2);
        check("t2_early", 32'(result_valid), 0);
        send(2, 1);
        verdict("t2", 1'b0, 2'd0);
        consume("t2");

        // last stage fails (19 < 20)
        send(11, 1); send(0, 1); send(19, 1);
        verdict("t3", 1'b0, 2'd2);

        // verdict held under backpressure; offered beat must not be consumed
        din_valid = 1'b1;
        din_data  = 14'd100;
        din_eot   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            verdict("bp", 1'b0, 2'd2);
        end
        din_valid = 1'b0;
        consume("bp");
        // 4+5=9 fails stage 0 only if the offered 100 was never accumulated
        send(4, 0); send(5, 1); send(1, 1); send(2, 1);
        verdict("bp_next", 1'b0, 2'd0);
        consume("bp_next");

        // positive and negative clamp, window passes
        set_thr(32767, -32768, 0);
        for (int i = 0; i < 5; i++) send(8191, i == 4);
        check("sat_pos_addr", 32'(stage_addr), 1);
        for (int i = 0; i < 5; i++) send(-8192, i == 4);
        send(0, 1);
        verdict("sat", 1'b1, 2'd2);
        consume("sat");

        // clamp then step back: 24576 passes, -24577 fails against -24576
        set_thr(24576, -24576, 0);
        for (int i = 0; i < 5; i++) send(8191, 0);
        send(-8191, 1);
        for (int i = 0; i < 5; i++) send(-8192, 0);
        send(8191, 1);
        send(0, 1);
        verdict("sat2", 1'b0, 2'd1);
        consume("sat2");

        // asynchronous reset mid stage 1
        set_thr(10, -5, 20);
        send(4, 0); send(7, 1); send(1, 0);
        check("ar_addr_pre", 32'(stage_addr), 1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(result_valid), 0);
        check("ar_ready", 32'(din_ready), 0);
        check("ar_addr", 32'(stage_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(4, 0); send(7, 1); send(-3, 1); send(15, 0); send(5, 1);
        verdict("ar_t1", 1'b1, 2'd2);
        consume("ar_t1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
